// File: rtl/mul_signed_arbiter.sv
// Round-robin share of one 8x8 signed multiplier across N requesters; result 2 cycles after grant.
// Backpressure: S2 holds while !res_ready; grants stop (gnt=0) once S1 and S2 are both full.
module mul_signed_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*8-1:0]    a_in,
    input  logic [N*8-1:0]    b_in,
    output logic [N-1:0]      gnt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic [15:0]       res_z
);

    logic              r_s1_v;
    logic [7:0]        r_s1_a;
    logic [7:0]        r_s1_b;
    logic [IDW-1:0]    r_s1_id;
    logic [IDW-1:0]    r_last;

    logic              w_out_free;
    logic              w_s1_go;
    logic              w_s1_free;
    logic              w_gnt_any;
    logic              w_grant;
    logic [IDW-1:0]    w_gnt_idx;
    logic [7:0]        w_a;
    logic [7:0]        w_b;
    logic [15:0]       w_prod;

    assign w_out_free = !res_valid || res_ready;
    assign w_s1_go    = r_s1_v && w_out_free;
    assign w_s1_free  = !r_s1_v || w_out_free;

    // Scan from farthest to nearest offset so the nearest set bit after r_last wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && (i == (int'(r_last) + k) % N)) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = IDW'(i);
                end
            end
        end
    end

    // Reset gates the grant so no requester sees a pulse that cannot be honoured.
    assign w_grant = !rst && w_s1_free && w_gnt_any;

    always_comb begin
        gnt = '0;
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_a = a_in[i*8 +: 8];
                w_b = b_in[i*8 +: 8];
                gnt[i] = w_grant;
            end
        end
    end

    // Sign-extended operands: the low 16 bits of the product are the exact signed result.
    assign w_prod = {{8{r_s1_a[7]}}, r_s1_a} * {{8{r_s1_b[7]}}, r_s1_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_id   <= '0;
            r_last    <= IDW'(N - 1);
            res_valid <= 1'b0;
            res_id    <= '0;
            res_z     <= '0;
        end else begin
            if (w_s1_go) begin
                res_valid <= 1'b1;
                res_id    <= r_s1_id;
                res_z     <= w_prod;
            end else if (w_out_free) begin
                res_valid <= 1'b0;
            end

            if (w_grant) begin
                r_s1_v  <= 1'b1;
                r_s1_a  <= w_a;
                r_s1_b  <= w_b;
                r_s1_id <= w_gnt_idx;
                r_last  <= w_gnt_idx;
            end else if (w_s1_free) begin
                r_s1_v  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_signed_arbiter.sv
// Bench for mul_signed_arbiter: queue-based reference model checked every cycle plus directed literals.
module tb_mul_signed_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*8-1:0]   a_in;
    logic [N*8-1:0]   b_in;
    logic [N-1:0]     gnt;
    logic             res_valid;
    logic             res_ready;
    logic [IDW-1:0]   res_id;
    logic [15:0]      res_z;

    mul_signed_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_z     (res_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [IDW-1:0] id;
        logic [15:0]    z;
        int             g;
    } ent_t;

    // Model: in-flight products in grant order; each becomes visible two cycles after its grant.
    ent_t q[$];
    ent_t acc_log[$];
    int   last_m = N - 1;
    int   cyc = 0;

    logic             m_ev;
    logic             m_allowed;
    logic             m_found;
    int               m_idx;
    int               m_j;
    logic [N-1:0]     m_gnt;
    logic signed [7:0] m_sa;
    logic signed [7:0] m_sb;
    int               m_p;
    ent_t             m_e;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_valid", 32'(res_valid), 32'h0);
            chk("rst_id", 32'(res_id), 32'h0);
            chk("rst_z", 32'(res_z), 32'h0);
            q.delete();
            last_m = N - 1;
            cyc = 0;
        end else begin
            m_ev = (q.size() > 0) && (q[0].g <= cyc - 2);
            chk("model_valid", 32'(res_valid), 32'(m_ev));
            if (m_ev) begin
                chk("model_id", 32'(res_id), 32'(q[0].id));
                chk("model_z", 32'(res_z), 32'(q[0].z));
            end
            m_allowed = (q.size() < 2) || res_ready;
            m_found = 1'b0;
            m_idx = 0;
            if (m_allowed) begin
                for (int k = 1; k <= N; k++) begin
                    m_j = (last_m + k) % N;
                    if (!m_found && req[m_j[1:0]]) begin
                        m_found = 1'b1;
                        m_idx = m_j;
                    end
                end
            end
            m_gnt = m_found ? N'(1 << m_idx) : '0;
            chk("model_gnt", 32'(gnt), 32'(m_gnt));
            if (m_ev && res_ready) begin
                acc_log.push_back(q[0]);
                void'(q.pop_front());
            end
            if (m_found) begin
                m_sa = 8'(a_in >> (8 * m_idx));
                m_sb = 8'(b_in >> (8 * m_idx));
                m_p = m_sa * m_sb;
                m_e.id = IDW'(m_idx);
                m_e.z = 16'(m_p);
                m_e.g = cyc;
                q.push_back(m_e);
                last_m = m_idx;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input int idx, input logic [IDW-1:0] id, input logic [15:0] z);
        if (idx < acc_log.size()) begin
            chk({name, "_id"}, 32'(acc_log[idx].id), 32'(id));
            chk({name, "_z"}, 32'(acc_log[idx].z), 32'(z));
        end else begin
            chk({name, "_present"}, 32'(acc_log.size()), 32'(idx + 1));
        end
    endtask

    logic [15:0] t2z [4] = '{16'h3f01, 16'h3f01, 16'hc17e, 16'hc27a};
    int ngr;

    initial begin
        rst = 1'b1;
        req = '0;
        a_in = '0;
        b_in = '0;
        res_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Single request, -1 * -1
        req = 4'b0001;
        a_in = {8'h00, 8'h00, 8'h00, 8'hff};
        b_in = {8'h00, 8'h00, 8'h00, 8'hff};
        #1 chk("t1_gnt", 32'(gnt), 32'h1);
        step();
        req = '0;
        step();
        #1;
        chk("t1_valid", 32'(res_valid), 32'h1);
        chk("t1_id", 32'(res_id), 32'h0);
        chk("t1_z", 32'(res_z), 32'h0001);

        // All four requesting, full throughput
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        acc_log.delete();
        a_in = {8'h82, 8'h7e, 8'h81, 8'h7f};
        b_in = {8'h7d, 8'h81, 8'h81, 8'h7f};
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 chk($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(1 << (k % 4)));
            step();
        end
        req = '0;
        step();
        step();
        step();
        chk("t2_count", 32'(acc_log.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            chk_log($sformatf("t2_res%0d", k), k, IDW'(k % 4), t2z[k % 4]);

        // Backpressure with three requesters
        acc_log.delete();
        a_in = {8'h00, 8'h01, 8'h80, 8'h80};
        b_in = {8'hff, 8'h80, 8'h7f, 8'h80};
        res_ready = 1'b0;
        req = 4'b0111;
        ngr = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (gnt != 0) ngr++;
            if (k == 0) chk("t3_gnt0", 32'(gnt), 32'h1);
            if (k == 1) chk("t3_gnt1", 32'(gnt), 32'h2);
            if (k >= 2) begin
                chk($sformatf("t3_gnt%0d", k), 32'(gnt), 32'h0);
                chk($sformatf("t3_hold_valid%0d", k), 32'(res_valid), 32'h1);
                chk($sformatf("t3_hold_id%0d", k), 32'(res_id), 32'h0);
                chk($sformatf("t3_hold_z%0d", k), 32'(res_z), 32'h4000);
            end
            step();
        end
        chk("t3_grants", 32'(ngr), 32'd2);
        res_ready = 1'b1;
        req = '0;
        step();
        step();
        step();
        chk("t3_count", 32'(acc_log.size()), 32'd2);
        chk_log("t3_res0", 0, 2'd0, 16'h4000);
        chk_log("t3_res1", 1, 2'd1, 16'hc080);

        // Single requester repeat, then pointer wrap 3 -> 0 -> 3
        acc_log.delete();
        req = 4'b1000;
        #1 chk("t4_gnt0", 32'(gnt), 32'h8);
        step();
        #1 chk("t4_gnt1", 32'(gnt), 32'h8);
        step();
        req = 4'b1001;
        #1 chk("t4_gnt2", 32'(gnt), 32'h1);
        step();
        #1 chk("t4_gnt3", 32'(gnt), 32'h8);
        step();
        req = '0;
        step();
        step();
        step();
        chk("t4_count", 32'(acc_log.size()), 32'd4);
        chk_log("t4_res0", 0, 2'd3, 16'h0000);
        chk_log("t4_res1", 1, 2'd3, 16'h0000);
        chk_log("t4_res2", 2, 2'd0, 16'h4000);
        chk_log("t4_res3", 3, 2'd3, 16'h0000);

        // Reset while S1 and S2 are both full
        a_in = {8'h01, 8'h7f, 8'h80, 8'h80};
        b_in = {8'h80, 8'h80, 8'h7f, 8'h80};
        res_ready = 1'b0;
        req = 4'b1111;
        step();
        step();
        #1;
        chk("t5_full_valid", 32'(res_valid), 32'h1);
        chk("t5_full_gnt", 32'(gnt), 32'h0);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(res_valid), 32'h0);
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        step();
        rst = 1'b0;
        res_ready = 1'b1;
        #1 chk("t5_first_gnt", 32'(gnt), 32'h1);
        step();
        req = '0;
        step();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
